// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch in T0-T2, per-opcode execute steps in T3-T7.
// Define MULDIV_EN to enable the mul/div execute sequences (otherwise they decode as nop).
module control_unit #(
  parameter logic [3:0] ALU_ADD = 4'd3,
  parameter logic [3:0] ALU_AND = 4'd10,
  parameter logic [3:0] ALU_OR  = 4'd11,
  parameter logic [3:0] ALU_MUL = 4'd15,
  parameter logic [3:0] ALU_DIV = 4'd0
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic [3:0]  CONTROL,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        COut,
  output logic        con_in,
  output logic        highin,
  output logic        lowin,
  output logic        HIout,
  output logic        LOout,
  output logic        inPortOut,
  output logic        outPortIn,
  output logic        ram_enable
);

  localparam int B_PCOUT = 0,  B_MARIN = 1,  B_INCPC = 2,   B_ZLOWIN = 3,  B_ZHIGHIN = 4;
  localparam int B_ZLOWOUT = 5, B_ZHIGHOUT = 6, B_PCIN = 7, B_READ = 8,   B_MDRIN = 9;
  localparam int B_MDROUT = 10, B_IRIN = 11,  B_YIN = 12,   B_GRA = 13,    B_GRB = 14;
  localparam int B_GRC = 15,   B_RIN = 16,    B_ROUT = 17,  B_BAOUT = 18,  B_COUT = 19;
  localparam int B_CONIN = 20, B_HIGHIN = 21, B_LOWIN = 22, B_HIOUT = 23,  B_LOOUT = 24;
  localparam int B_INPORT = 25, B_OUTPORT = 26, B_RAMEN = 27;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] strobe;
  logic [4:0]  opcode;
  logic        ir_unused;
  logic        is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_jr, is_in, is_out;
  logic        is_mfhi, is_mflo, is_halt, is_md, is_short, has_exec;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  always_comb begin
    is_alu   = opcode inside {5'b00011, 5'b00100, 5'b00101, 5'b00111, 5'b01010, 5'b01011};
    is_imm   = opcode inside {5'b01100, 5'b01101, 5'b01110};
    is_ldi   = (opcode == 5'b00001);
    is_ld    = (opcode == 5'b00000);
    is_st    = (opcode == 5'b00010);
    is_br    = (opcode == 5'b10011);
    is_jr    = (opcode == 5'b10100);
    is_in    = (opcode == 5'b10110);
    is_out   = (opcode == 5'b10111);
    is_mfhi  = (opcode == 5'b11000);
    is_mflo  = (opcode == 5'b11001);
    is_halt  = (opcode == 5'b11011);
`ifdef MULDIV_EN
    is_md    = (opcode == 5'b01111) || (opcode == 5'b10000);
`else
    is_md    = 1'b0;
`endif
    is_short = is_jr || is_in || is_out || is_mfhi || is_mflo;
    has_exec = is_alu || is_imm || is_ldi || is_ld || is_st || is_br || is_short ||
               is_halt || is_md;
  end

`ifndef MULDIV_EN
  // mul/div codes are only meaningful when the multiply/divide sequence exists
  localparam logic [3:0] md_codes_unused = ALU_MUL ^ ALU_DIV;
`endif

  always_ff @(posedge Clock) begin
    if (Clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = Stop ? S_HALT : S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = has_exec ? S_T3 : S_T0;
      S_T3:    state_d = is_halt ? S_HALT : (is_short ? S_T0 : S_T4);
      S_T4:    state_d = S_T5;
      S_T5:    state_d = (is_alu || is_imm || is_ldi) ? S_T0 : S_T6;
      S_T6:    state_d = (is_br || is_md) ? S_T0 : S_T7;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    strobe  = '0;
    CONTROL = ALU_ADD;
    Run     = 1'b1;
    case (state_q)
      S_RESET: begin
        Run     = 1'b0;
        CONTROL = 4'd0;
      end
      S_HALT: Run = 1'b0;
      S_T0: begin
        strobe[B_PCOUT] = 1'b1; strobe[B_MARIN] = 1'b1;
        strobe[B_INCPC] = 1'b1; strobe[B_ZLOWIN] = 1'b1;
      end
      S_T1: begin
        strobe[B_ZLOWOUT] = 1'b1; strobe[B_PCIN] = 1'b1;
        strobe[B_READ] = 1'b1;    strobe[B_MDRIN] = 1'b1;
      end
      S_T2: begin
        strobe[B_MDROUT] = 1'b1; strobe[B_IRIN] = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_imm) begin
          strobe[B_GRB] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_YIN] = 1'b1;
        end
        if (is_ldi || is_ld || is_st) begin
          strobe[B_GRB] = 1'b1; strobe[B_BAOUT] = 1'b1; strobe[B_YIN] = 1'b1;
        end
        if (is_md) begin
          strobe[B_GRA] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_YIN] = 1'b1;
        end
        if (is_br) begin
          strobe[B_GRA] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_CONIN] = 1'b1;
        end
        if (is_jr) begin
          strobe[B_GRA] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_PCIN] = 1'b1;
        end
        if (is_in) begin
          strobe[B_INPORT] = 1'b1; strobe[B_GRA] = 1'b1; strobe[B_RIN] = 1'b1;
        end
        if (is_out) begin
          strobe[B_GRA] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_OUTPORT] = 1'b1;
        end
        if (is_mfhi) begin
          strobe[B_HIOUT] = 1'b1; strobe[B_GRA] = 1'b1; strobe[B_RIN] = 1'b1;
        end
        if (is_mflo) begin
          strobe[B_LOOUT] = 1'b1; strobe[B_GRA] = 1'b1; strobe[B_RIN] = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          strobe[B_GRC] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_ZLOWIN] = 1'b1;
          CONTROL = opcode[3:0];
        end
        if (is_imm || is_ldi || is_ld || is_st) begin
          strobe[B_COUT] = 1'b1; strobe[B_ZLOWIN] = 1'b1;
        end
        if (is_imm) CONTROL = (opcode == 5'b01100) ? ALU_ADD :
                              (opcode == 5'b01101) ? ALU_AND : ALU_OR;
        if (is_br) begin
          strobe[B_PCOUT] = 1'b1; strobe[B_YIN] = 1'b1;
        end
        if (is_md) begin
          strobe[B_GRB] = 1'b1;    strobe[B_ROUT] = 1'b1;
          strobe[B_ZLOWIN] = 1'b1; strobe[B_ZHIGHIN] = 1'b1;
          CONTROL = (opcode == 5'b01111) ? ALU_MUL : ALU_DIV;
        end
      end
      S_T5: begin
        if (is_alu || is_imm || is_ldi) begin
          strobe[B_ZLOWOUT] = 1'b1; strobe[B_GRA] = 1'b1; strobe[B_RIN] = 1'b1;
        end
        if (is_ld || is_st) begin
          strobe[B_ZLOWOUT] = 1'b1; strobe[B_MARIN] = 1'b1;
        end
        if (is_br) begin
          strobe[B_COUT] = 1'b1; strobe[B_ZLOWIN] = 1'b1;
        end
        if (is_md) begin
          strobe[B_ZLOWOUT] = 1'b1; strobe[B_LOWIN] = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          strobe[B_READ] = 1'b1; strobe[B_MDRIN] = 1'b1;
        end
        if (is_st) begin
          strobe[B_GRA] = 1'b1; strobe[B_ROUT] = 1'b1; strobe[B_MDRIN] = 1'b1;
        end
        // branch target is committed only when the condition flag is set
        if (is_br) begin
          strobe[B_ZLOWOUT] = 1'b1; strobe[B_PCIN] = CON;
        end
        if (is_md) begin
          strobe[B_ZHIGHOUT] = 1'b1; strobe[B_HIGHIN] = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          strobe[B_MDROUT] = 1'b1; strobe[B_GRA] = 1'b1; strobe[B_RIN] = 1'b1;
        end
        if (is_st) strobe[B_RAMEN] = 1'b1;
      end
      default: begin
        Run     = 1'b0;
        CONTROL = 4'd0;
      end
    endcase
  end

  assign {ram_enable, outPortIn, inPortOut, LOout, HIout, lowin, highin, con_in, COut, BAout,
          Rout, Rin, Grc, Grb, Gra, Yin, IRin, MDRout, MDRin, Read, PCin, Zhighout, Zlowout,
          Zhighin, Zlowin, IncPC, MARin, PCout} = strobe;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks plus randomized instruction streams
// compared every cycle against an instruction-plan reference model.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic        Stop = 1'b0;
  logic        Run;
  logic [3:0]  CONTROL;
  logic PCout, MARin, IncPC, Zlowin, Zhighin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout;
  logic IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, COut, con_in, highin, lowin, HIout, LOout;
  logic inPortOut, outPortIn, ram_enable;

  int total = 0;
  int bad = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
    .CONTROL(CONTROL), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .COut(COut), .con_in(con_in), .highin(highin),
    .lowin(lowin), .HIout(HIout), .LOout(LOout), .inPortOut(inPortOut),
    .outPortIn(outPortIn), .ram_enable(ram_enable)
  );

  always #5 Clock = ~Clock;

  logic [27:0] act;
  assign act = {ram_enable, outPortIn, inPortOut, LOout, HIout, lowin, highin, con_in, COut,
                BAout, Rout, Rin, Grc, Grb, Gra, Yin, IRin, MDRout, MDRin, Read, PCin, Zhighout,
                Zlowout, Zhighin, Zlowin, IncPC, MARin, PCout};

  localparam logic [27:0] PCOUT = 28'd1 << 0,  MARIN = 28'd1 << 1,  INCPC = 28'd1 << 2;
  localparam logic [27:0] ZLOWIN = 28'd1 << 3, ZHIGHIN = 28'd1 << 4, ZLOWOUT = 28'd1 << 5;
  localparam logic [27:0] ZHIGHOUT = 28'd1 << 6, PCIN = 28'd1 << 7, READ = 28'd1 << 8;
  localparam logic [27:0] MDRIN = 28'd1 << 9,  MDROUT = 28'd1 << 10, IRIN = 28'd1 << 11;
  localparam logic [27:0] YIN = 28'd1 << 12,   GRA = 28'd1 << 13,    GRB = 28'd1 << 14;
  localparam logic [27:0] GRC = 28'd1 << 15,   RIN = 28'd1 << 16,    ROUT = 28'd1 << 17;
  localparam logic [27:0] BAOUT = 28'd1 << 18, COUTM = 28'd1 << 19,  CONIN = 28'd1 << 20;
  localparam logic [27:0] HIGHIN = 28'd1 << 21, LOWIN = 28'd1 << 22, HIOUT = 28'd1 << 23;
  localparam logic [27:0] LOOUT = 28'd1 << 24, INPORT = 28'd1 << 25, OUTPORT = 28'd1 << 26;
  localparam logic [27:0] RAMEN = 28'd1 << 27;
  localparam logic [27:0] FETCH0 = PCOUT | MARIN | INCPC | ZLOWIN;

  // Instruction classes: 0 nop, 1 alu, 2 imm, 3 ldi, 4 ld, 5 st, 6 br, 7 one-step, 8 halt, 9 mul/div
  function automatic int cls(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd7, 5'd10, 5'd11: return 1;
      5'd12, 5'd13, 5'd14: return 2;
      5'd1:  return 3;
      5'd0:  return 4;
      5'd2:  return 5;
      5'd19: return 6;
      5'd20, 5'd22, 5'd23, 5'd24, 5'd25: return 7;
      5'd27: return 8;
`ifdef MULDIV_EN
      5'd15, 5'd16: return 9;
`endif
      default: return 0;
    endcase
  endfunction

  // Cycles from T0 through the last step of the instruction
  function automatic int instr_len(input logic [4:0] op);
    int lens[10] = '{3, 6, 6, 6, 8, 8, 7, 4, 4, 7};
    return lens[cls(op)];
  endfunction

  // {CONTROL, strobes} expected at cycle idx of the instruction (idx 0 = T0)
  function automatic logic [31:0] step_out(input logic [4:0] op, input logic con, input int idx);
    logic [27:0] s = '0;
    logic [3:0]  c = 4'd3;
    int k = cls(op);
    if (idx == 0) s = FETCH0;
    else if (idx == 1) s = ZLOWOUT | PCIN | READ | MDRIN;
    else if (idx == 2) s = MDROUT | IRIN;
    else if (k == 1 || k == 2) begin
      if (idx == 3) s = GRB | ROUT | YIN;
      if (idx == 4) begin
        s = (k == 1) ? (GRC | ROUT | ZLOWIN) : (COUTM | ZLOWIN);
        if (k == 1) c = op[3:0];
        else c = (op == 5'd12) ? 4'd3 : (op == 5'd13) ? 4'd10 : 4'd11;
      end
      if (idx == 5) s = ZLOWOUT | GRA | RIN;
    end else if (k >= 3 && k <= 5) begin
      if (idx == 3) s = GRB | BAOUT | YIN;
      if (idx == 4) s = COUTM | ZLOWIN;
      if (idx == 5) s = (k == 3) ? (ZLOWOUT | GRA | RIN) : (ZLOWOUT | MARIN);
      if (idx == 6) s = (k == 4) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
      if (idx == 7) s = (k == 4) ? (MDROUT | GRA | RIN) : RAMEN;
    end else if (k == 6) begin
      if (idx == 3) s = GRA | ROUT | CONIN;
      if (idx == 4) s = PCOUT | YIN;
      if (idx == 5) s = COUTM | ZLOWIN;
      if (idx == 6) s = con ? (ZLOWOUT | PCIN) : ZLOWOUT;
    end else if (k == 7) begin
      case (op)
        5'd20:   s = GRA | ROUT | PCIN;
        5'd22:   s = INPORT | GRA | RIN;
        5'd23:   s = GRA | ROUT | OUTPORT;
        5'd24:   s = HIOUT | GRA | RIN;
        default: s = LOOUT | GRA | RIN;
      endcase
    end else if (k == 9) begin
      if (idx == 3) s = GRA | ROUT | YIN;
      if (idx == 4) begin
        s = GRB | ROUT | ZLOWIN | ZHIGHIN;
        c = (op == 5'd15) ? 4'd15 : 4'd0;
      end
      if (idx == 5) s = ZLOWOUT | LOWIN;
      if (idx == 6) s = ZHIGHOUT | HIGHIN;
    end
    return {c, s};
  endfunction

  // Model: mode 0 = reset, 1 = running an instruction, 2 = halted
  int m_mode = 0;
  int m_idx = 0;

  task automatic model_step();
    logic [4:0] op = IR[31:27];
    if (Clear) m_mode = 0;
    else if (m_mode == 0) begin
      m_mode = 1;
      m_idx = 0;
    end else if (m_mode == 1) begin
      if (m_idx == 0 && Stop) m_mode = 2;
      else if (m_idx + 1 >= instr_len(op)) begin
        if (cls(op) == 8) m_mode = 2;
        else m_idx = 0;
      end else m_idx++;
    end
  endtask

  task automatic model_check();
    logic [32:0] exp_v, got_v;
    if (m_mode == 1) exp_v = {1'b1, step_out(IR[31:27], CON, m_idx)};
    else if (m_mode == 2) exp_v = {1'b0, 4'd3, 28'd0};
    else exp_v = {1'b0, 4'd0, 28'd0};
    got_v = {Run, CONTROL, act};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL model t=%0t mode=%0d idx=%0d ir=%h got run/ctl/strobes=%h want=%h",
               $time, m_mode, m_idx, IR, got_v, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    model_check();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic lit(input string name, input logic [32:0] got_v, input logic [32:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got_v, exp_v);
    end
  endtask

  initial begin
    logic [4:0] rop;
    cycn(2);
    lit("reset", {Run, CONTROL, act}, {1'b0, 4'd0, 28'd0});
    Clear = 1'b0;
    cyc();
    lit("t0_after_reset", {Run, CONTROL, act}, {1'b1, 4'd3, FETCH0});

    IR = 32'h19918000;
    cycn(4);
    lit("add_t4", {Run, CONTROL, act}, {1'b1, 4'd3, GRC | ROUT | ZLOWIN});
    cyc();
    lit("add_t5", {Run, CONTROL, act}, {1'b1, 4'd3, ZLOWOUT | GRA | RIN});
    cyc();
    lit("add_len6", {Run, CONTROL, act}, {1'b1, 4'd3, FETCH0});

    IR = 32'h00800055;
    cycn(5);
    lit("ld_t5", {Run, CONTROL, act}, {1'b1, 4'd3, ZLOWOUT | MARIN});
    cyc();
    lit("ld_t6", {Run, CONTROL, act}, {1'b1, 4'd3, READ | MDRIN});
    cyc();
    lit("ld_t7", {Run, CONTROL, act}, {1'b1, 4'd3, MDROUT | GRA | RIN});
    cyc();
    lit("ld_len8", {Run, CONTROL, act}, {1'b1, 4'd3, FETCH0});

    IR = 32'h98000000;
    CON = 1'b0;
    cycn(6);
    lit("br_con0_t6", {Run, CONTROL, act}, {1'b1, 4'd3, ZLOWOUT});
    cyc();
    CON = 1'b1;
    cycn(6);
    lit("br_con1_t6", {Run, CONTROL, act}, {1'b1, 4'd3, ZLOWOUT | PCIN});
    cyc();
    CON = 1'b0;

    IR = 32'h78000000;
`ifdef MULDIV_EN
    cycn(4);
    lit("mul_t4", {Run, CONTROL, act}, {1'b1, 4'd15, GRB | ROUT | ZLOWIN | ZHIGHIN});
    cycn(2);
    lit("mul_t6", {Run, CONTROL, act}, {1'b1, 4'd3, ZHIGHOUT | HIGHIN});
    cyc();
`else
    cycn(3);
    lit("mul_as_nop", {Run, CONTROL, act}, {1'b1, 4'd3, FETCH0});
`endif

    Stop = 1'b1;
    cyc();
    Stop = 1'b0;
    lit("stop_halt", {31'd0, Run, PCout}, 33'd0);
    cycn(3);
    lit("stop_halt_held", {32'd0, Run}, 33'd0);

    Clear = 1'b1;
    cyc();
    Clear = 1'b0;
    cyc();
    IR = 32'hD8000000;
    cycn(3);
    lit("halt_t3", {Run, CONTROL, act}, {1'b1, 4'd3, 28'd0});
    for (int i = 0; i < 20; i++) begin
      cyc();
      lit("halt_run_low", {32'd0, Run}, 33'd0);
    end

    Clear = 1'b1;
    cyc();
    Clear = 1'b0;
    cyc();
    IR = 32'h19918000;
    cycn(4);
    Clear = 1'b1;
    cyc();
    lit("clear_mid_t4", {Run, CONTROL, act}, {1'b0, 4'd0, 28'd0});
    cyc();
    lit("clear_held", {Run, CONTROL, act}, {1'b0, 4'd0, 28'd0});
    Clear = 1'b0;
    cyc();
    lit("t0_after_clear", {Run, CONTROL, act}, {1'b1, 4'd3, FETCH0});

    for (int c = 0; c < 5000; c++) begin
      if (m_mode == 1 && m_idx == 0) begin
        rop = 5'($urandom_range(0, 31));
        IR = {rop, 27'($urandom)};
      end
      Clear = (m_mode == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
      Stop = ($urandom_range(0, 11) == 0);
      CON = 1'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
